// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_pkg
// Purpose  : Shared types and constants for the pipeline hazard/stall
//            controller: memory-handshake state encoding and the x0 register
//            address.
// Revision : 1.0  initial release
// ============================================================================
package pipeline_pkg;

    // Memory-handshake controller states
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERR      = 2'b10
    } state_t;

    // Architectural zero register; writes to it never create a hazard
    localparam logic [4:0] X0 = 5'd0;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl_if
// Purpose  : Bundles the hazard inputs, memory handshake and pipeline control
//            outputs of the pipeline controller.
// Ports    : master - pipeline side: drives hazard/handshake inputs, observes
//                     controls, error flag and event counters.
//            slave  - controller side: the mirror image.
// Revision : 1.0  initial release
// ============================================================================
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    // Hazard sources
    logic [4:0]       ID_RS1addr_i;
    logic [4:0]       ID_RS2addr_i;
    logic             EX_MemRead_i;
    logic [4:0]       EX_RDaddr_i;
    logic             ID_BranchTaken_i;
    // Data-memory handshake
    logic             MEM_Access_i;
    logic             dmem_ack_i;
    logic             dmem_req_o;
    // Pipeline controls
    logic             PCWrite_o;
    logic             IFID_Stall_o;
    logic             IFID_Flush_o;
    logic             IDEX_Bubble_o;
    logic             Freeze_o;
    // Status / performance counters
    logic             err_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output ID_RS1addr_i, ID_RS2addr_i, EX_MemRead_i, EX_RDaddr_i,
               ID_BranchTaken_i, MEM_Access_i, dmem_ack_i,
        input  dmem_req_o, PCWrite_o, IFID_Stall_o, IFID_Flush_o,
               IDEX_Bubble_o, Freeze_o, err_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  ID_RS1addr_i, ID_RS2addr_i, EX_MemRead_i, EX_RDaddr_i,
               ID_BranchTaken_i, MEM_Access_i, dmem_ack_i,
        output dmem_req_o, PCWrite_o, IFID_Stall_o, IFID_Flush_o,
               IDEX_Bubble_o, Freeze_o, err_o, stall_cnt_o, flush_cnt_o
    );

endinterface : pipeline_ctrl_if
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Event counter that increments on inc and sticks at all-ones.
// Ports    : clk_i  - clock, rising edge
//            rst_i  - asynchronous active-low reset, clears the count
//            inc    - count one event at the next rising edge
//            value  - current count
// Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int W = 32
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    input  wire logic         inc,
    output logic      [W-1:0] value
);

    logic [W-1:0] r_value;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_value <= '0;
        end else if (inc && (r_value != '1)) begin
            r_value <= r_value + 1'b1;
        end
    end

    assign value = r_value;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Purpose  : Central hazard and stall controller for the 5-stage RV32
//            pipeline. Detects load-use hazards and taken branches, runs the
//            data-memory request/acknowledge handshake for the instruction in
//            MEM with a wait-timeout error trap, and keeps saturating stall
//            and flush event counters.
// Ports    : clk_i   - clock, rising edge
//            rst_i   - asynchronous active-low reset
//            ctrl_if - pipeline_ctrl_if.slave: hazard inputs, memory
//                      handshake, pipeline controls, error flag, counters
// Revision : 1.0  initial release
// ============================================================================
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    pipeline_ctrl_if.slave   ctrl_if
);

    // Wait counter is sized to hold 0 .. TIMEOUT-1
    localparam int              WAIT_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t              r_state;
    logic [WAIT_W-1:0]   r_wait_cnt;

    logic w_loaduse;
    logic w_req;
    logic w_freeze;
    logic w_err;
    logic w_pcwrite;
    logic w_ifid_stall;
    logic w_ifid_flush;
    logic w_idex_bubble;
    logic w_stall_inc;

    // ------------------------------------------------------------------
    // Memory handshake FSM. The cycle that first raises the request is
    // spent in RUN; only the ack-less cycles after it count towards the
    // timeout.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (ctrl_if.MEM_Access_i && !ctrl_if.dmem_ack_i) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (ctrl_if.dmem_ack_i) begin
                        r_state <= RUN;
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        r_state <= ERR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ERR: begin
                    // Sticky until reset
                    r_state <= ERR;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    // Load-use: a load in EX writes a register the instruction in ID reads
    assign w_loaduse = ctrl_if.EX_MemRead_i
                     && (ctrl_if.EX_RDaddr_i != X0)
                     && ((ctrl_if.EX_RDaddr_i == ctrl_if.ID_RS1addr_i)
                      || (ctrl_if.EX_RDaddr_i == ctrl_if.ID_RS2addr_i));

    // ------------------------------------------------------------------
    // Handshake outputs and freeze. All are forced low while reset is
    // held so an in-flight access is abandoned without waiting for a clock.
    // ------------------------------------------------------------------
    always_comb begin
        w_req    = 1'b0;
        w_err    = 1'b0;
        case (r_state)
            RUN:      w_req = ctrl_if.MEM_Access_i;
            MEM_WAIT: w_req = 1'b1;
            ERR:      w_err = 1'b1;
            default:  w_req = 1'b0;
        endcase
        w_freeze = (w_req && !ctrl_if.dmem_ack_i) || w_err;
        if (!rst_i) begin
            w_req    = 1'b0;
            w_freeze = 1'b0;
            w_err    = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Hazard priority: freeze > load-use > taken branch > normal flow.
    // A branch coinciding with a load-use stall is dropped; the branch
    // re-resolves in ID on the next cycle once the load data is available.
    // ------------------------------------------------------------------
    always_comb begin
        w_pcwrite     = 1'b1;
        w_ifid_stall  = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        if (w_freeze) begin
            w_pcwrite     = 1'b0;
            w_ifid_stall  = 1'b1;
        end else if (w_loaduse) begin
            w_pcwrite     = 1'b0;
            w_ifid_stall  = 1'b1;
            w_idex_bubble = 1'b1;
        end else if (ctrl_if.ID_BranchTaken_i) begin
            w_ifid_flush  = 1'b1;
        end
        if (!rst_i) begin
            w_pcwrite     = 1'b0;
            w_ifid_stall  = 1'b0;
            w_ifid_flush  = 1'b0;
            w_idex_bubble = 1'b0;
        end
    end

    // A cycle counts as a stall whether it was caused by a freeze or a
    // load-use bubble
    assign w_stall_inc = w_freeze || w_loaduse;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc   (w_stall_inc),
        .value (ctrl_if.stall_cnt_o)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc   (w_ifid_flush),
        .value (ctrl_if.flush_cnt_o)
    );

    assign ctrl_if.dmem_req_o    = w_req;
    assign ctrl_if.Freeze_o      = w_freeze;
    assign ctrl_if.err_o         = w_err;
    assign ctrl_if.PCWrite_o     = w_pcwrite;
    assign ctrl_if.IFID_Stall_o  = w_ifid_stall;
    assign ctrl_if.IFID_Flush_o  = w_ifid_flush;
    assign ctrl_if.IDEX_Bubble_o = w_idex_bubble;

endmodule : pipeline_ctrl
`default_nettype wire

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and stall controller for the 5-stage RV32 pipeline. Generates PC write-enable, IF/ID stall/flush, ID/EX bubble insertion and a global freeze for all pipeline registers. Runs the data-memory request/acknowledge handshake for the instruction in MEM, with a wait-timeout error trap. Keeps saturating stall and flush event counters for performance debug.

## Interface
Parameters:
- TIMEOUT, 64: maximum MEM_WAIT cycles before the error trap.
- CNT_W, 32: width of the event counters.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- ID_RS1addr_i  in  5  rs1 of the instruction in ID.
- ID_RS2addr_i  in  5  rs2 of the instruction in ID.
- EX_MemRead_i  in  1  MemRead from the ID/EX register.
- EX_RDaddr_i  in  5  RDaddr from the ID/EX register.
- ID_BranchTaken_i  in  1  branch resolved taken in ID.
- MEM_Access_i  in  1  MemRead|MemWrite from the EX/MEM register.
- dmem_ack_i  in  1  data memory completes access this cycle.
- PCWrite_o  out  1  PC update enable.
- IFID_Stall_o  out  1  hold the IF/ID register.
- IFID_Flush_o  out  1  zero the IF/ID register.
- IDEX_Bubble_o  out  1  force ID/EX control bits to 0.
- Freeze_o  out  1  hold PC and all four pipeline registers.
- dmem_req_o  out  1  data memory request.
- err_o  out  1  sticky memory-timeout error.
- stall_cnt_o  out  CNT_W  stall-cycle count.
- flush_cnt_o  out  CNT_W  flush count.

## Operation
- FSM states:
  - RUN: dmem_req_o = MEM_Access_i.
    - MEM_Access_i & ~dmem_ack_i: go to MEM_WAIT and clear the wait counter.
    - Otherwise: stay in RUN.
  - MEM_WAIT: dmem_req_o = 1; the wait counter increments each cycle.
    - dmem_ack_i: go to RUN.
    - Counter reaches TIMEOUT-1 with no ack: go to ERR.
  - ERR: dmem_req_o = 0, err_o = 1, Freeze_o = 1. Exit only via reset.
- Freeze_o = dmem_req_o & ~dmem_ack_i, or state == ERR.
- Load-use condition (loaduse): EX_MemRead_i & (EX_RDaddr_i != 0) & (EX_RDaddr_i == ID_RS1addr_i | EX_RDaddr_i == ID_RS2addr_i).
- Priority, highest first:
  - Freeze: PCWrite_o=0, IFID_Stall_o=1, IDEX_Bubble_o=0, IFID_Flush_o=0.
  - loaduse: PCWrite_o=0, IFID_Stall_o=1, IDEX_Bubble_o=1, IFID_Flush_o=0. A branch taken in the same cycle is ignored; it re-resolves next cycle.
  - ID_BranchTaken_i: IFID_Flush_o=1, PCWrite_o=1.
  - Otherwise: PCWrite_o=1, all other controls 0.
- stall_cnt_o increments when Freeze_o | (loaduse & ~Freeze_o).
- flush_cnt_o increments when IFID_Flush_o.
- Both counters saturate at all-ones and do not wrap.

## Timing
- All control outputs are combinational from inputs and the registered state. There is zero-cycle latency from hazard to stall.
- With an ack in the same cycle as the request: no freeze and no state change. The access costs one cycle.
- With an ack after N wait cycles: Freeze_o is high for exactly N cycles. It drops combinationally in the ack cycle.
- Handshake: while in MEM_WAIT, dmem_req_o stays high until ack. An ack with no request is ignored.
- With TIMEOUT=64: err_o rises on the edge after the 64th ack-less MEM_WAIT cycle (the cycle that first asserted the request does not count).
- Reset, while rst_i is low, regardless of inputs:
  - state = RUN, wait counter = 0, err_o = 0, both counters = 0.
  - PCWrite_o, IFID_Stall_o, IFID_Flush_o, IDEX_Bubble_o, Freeze_o and dmem_req_o are all forced to 0.
- Reset asserted mid-MEM_WAIT or in ERR: abandon the access immediately. dmem_req_o drops asynchronously.
- Counter updates take effect on the next rising edge.

## Structure
- Shared package pipeline_pkg holds:
  - The state enum {RUN, MEM_WAIT, ERR}, 2-bit encoding 00/01/10.
  - Localparam X0 = 5'd0.
- Sub-module sat_counter (parameter W; ports inc, value), instantiated twice for the event counters.
- The wait counter is inline, $clog2(TIMEOUT) bits.

## Test plan
- Load-use: EX_MemRead_i=1, EX_RDaddr_i=5, ID_RS2addr_i=5 -> PCWrite_o=0, IFID_Stall_o=1, IDEX_Bubble_o=1; stall_cnt_o=1 next cycle. Repeat with EX_RDaddr_i=0 -> no stall.
- Branch: ID_BranchTaken_i=1 with no hazard -> IFID_Flush_o=1, flush_cnt_o increments. Same branch together with loaduse -> no flush, stall only.
- Memory wait: MEM_Access_i=1, ack after 3 cycles -> Freeze_o high for 3 cycles, dmem_req_o high for 4 cycles, stall_cnt_o=3.
- Timeout: MEM_Access_i=1 with no ack, TIMEOUT=4 -> ERR after 4 wait cycles; err_o=1, Freeze_o stays 1 and dmem_req_o=0 thereafter; late ack has no effect.
- Async reset in MEM_WAIT mid-cycle -> all outputs 0 immediately. After release: RUN, counters 0.
- Saturation with CNT_W=4: hold loaduse for 20 cycles -> stall_cnt_o stops at 15.
